ndma_desc_fetch: RTL
====================

# ndma_desc_fetch

Descriptor-chain front end for the nDMA engine. It walks a linked list of transfer descriptors in memory over its own OBI read manager and programs each descriptor into the nDMA configuration port. It then starts the transfer and waits for the engine's completion interrupt before following the next pointer. It sits directly upstream of the nDMA core, driving its `cfg_*` slave port and consuming `tx_done_irq`.

## Interface
Parameters:
- `MaxTxSize`, 256: largest legal descriptor length in words; must match the nDMA core.
- `CfgBase`, 32'h0: base address of the nDMA config registers as seen on `cfg_addr_o`.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_ni`, in, 1: reset, synchronous, active-low.
- `start_i`, in, 1: one-cycle pulse that starts a chain walk at `head_addr_i`; ignored unless IDLE.
- `head_addr_i`, in, 32: address of the first descriptor; bits [1:0] are ignored (forced to 0).
- `abort_i`, in, 1: request to stop the chain walk.
- `busy_o`, out, 1: high in every state except IDLE.
- `chain_done_o`, out, 1: one-cycle pulse after the last descriptor completes.
- `err_o`, out, 1: one-cycle pulse on an illegal descriptor.
- `desc_cnt_o`, out, 16: number of descriptors completed since the last start; wraps.
- `desc_mgr`, OBI_BUS.Manager: descriptor read port. Ties: `we`=0, `be`=4'hF, `wdata`=0.
- `cfg_req_o`, out, 1: config write request to the nDMA core.
- `cfg_we_o`, out, 1: config write enable; always 1.
- `cfg_gnt_i`, in, 1: config grant from the nDMA core.
- `cfg_addr_o`, out, 32: config register address.
- `cfg_wdata_o`, out, 32: config write data.
- `cfg_rvalid_i`, in, 1: config write response.
- `tx_done_irq_i`, in, 1: transfer-complete indication from the nDMA core.

## Operation
- Descriptor layout: 4 consecutive words at `ptr`.
  - +0x0: src
  - +0x4: dst
  - +0x8: len in words
  - +0xC: next; 0 terminates the chain, bits [1:0] are ignored.
- FSM states: IDLE, FETCH, FWAIT, CHECK, CFG, CWAIT, XFER.
- IDLE:
  - On `start_i`: `ptr`←`head_addr_i & ~3`, `widx`←0, `desc_cnt_o`←0, go to FETCH.
- FETCH:
  - `desc_mgr.req`=1, `addr`=`ptr + 4*widx`.
  - On `gnt`, go to FWAIT.
- FWAIT:
  - On `rvalid`: store `rdata` into word `widx`.
  - If `widx`==3, go to CHECK; otherwise increment `widx` and go to FETCH.
  - Exactly one read is outstanding at any time.
- CHECK (1 cycle):
  - If len==0 or len>`MaxTxSize`: pulse `err_o`, go to IDLE.
  - Otherwise `cidx`←0, go to CFG.
- CFG:
  - `cfg_req_o`=1. Address and data by `cidx`:
    - 0: `CfgBase+0x0`, src.
    - 1: `CfgBase+0x4`, dst.
    - 2: `CfgBase+0x8`, len (32-bit compare and write; the core truncates).
    - 3: `CfgBase+0xC`, 32'h1 (start).
  - On `cfg_gnt_i`, go to CWAIT.
- CWAIT:
  - On `cfg_rvalid_i`: if `cidx`==3, go to XFER; otherwise increment `cidx` and go to CFG.
- XFER:
  - On `tx_done_irq_i`: `desc_cnt_o`++.
  - If next==0: pulse `chain_done_o`, go to IDLE.
  - Otherwise `ptr`←`next & ~3`, `widx`←0, go to FETCH.
- Abort:
  - `abort_i` is sticky-latched while busy and cleared on entering IDLE.
  - Acted on only at safe points: entering FETCH or CFG, or in XFER. At those points the block goes to IDLE with no pulse on `chain_done_o` or `err_o`.
  - An outstanding OBI read or config write always completes first.
  - A running nDMA transfer is not stopped.
- Simultaneous `start_i` and `abort_i` in IDLE: start wins; the abort is dropped.

## Timing
- Reset values (synchronous, `rst_ni`=0 at a clock edge):
  - State IDLE.
  - All outputs 0, including `desc_mgr.req`, `cfg_req_o`, `desc_cnt_o`, and all pulses.
  - `cfg_we_o`=1 and `desc_mgr.be`=4'hF are constants.
- Reset mid-operation drops all handshakes on the next edge; no completion is awaited.
- All outputs are registered.
  - `start_i` sampled at edge N gives `desc_mgr.req`=1 from cycle N+1.
- Request rules (OBI and cfg):
  - `req`, `addr` and `wdata` stay stable until `gnt` is sampled high.
  - `req` drops in the cycle after `gnt`.
  - The response is accepted no earlier than the cycle after `gnt`.
- Best case with zero-wait `gnt` and `rvalid` one cycle later:
  - Each word or config write costs 2 cycles.
  - Fetch (8) + CHECK (1) + config (8) = 17 cycles from `start_i` to the first cycle of XFER.
- `tx_done_irq_i` is sampled only in XFER. Pulses in any other state are ignored.
- `chain_done_o` and `err_o` are high for exactly one cycle, in the cycle IDLE is entered; `busy_o` is 0 in that same cycle.

## Test plan
- Single descriptor at 0x100 = {0x1000, 0x2000, 8, 0}, zero-wait memory -> cfg writes (0x0,0x1000), (0x4,0x2000), (0x8,8), (0xC,1) in order. After `tx_done_irq_i`: `chain_done_o` pulses once, `desc_cnt_o`=1, 17 cycles from start to XFER.
- Three-descriptor chain 0x100→0x200→0x303 (read as 0x300) -> reads at 0x100–0x10C, 0x200–0x20C, 0x300–0x30C; 12 cfg writes; `desc_cnt_o`=3; one `chain_done_o`.
- Descriptor with len=0, then one with len=257 -> `err_o` pulses after the 4th read; no `cfg_req_o` is issued; `busy_o`=0 the next cycle.
- Random `gnt` stalls of 0–5 cycles and `rvalid` delays of 1–4 cycles on both ports -> `addr` and `wdata` stable while stalled, never more than one read outstanding, same cfg sequence as the zero-wait case.
- `abort_i` during FWAIT of word 2 -> the pending `rvalid` is consumed, the block enters IDLE, no word-3 request and no pulse. `abort_i` during XFER -> IDLE the next cycle.
- `rst_ni`=0 for one edge while in CWAIT -> all outputs 0 the next cycle; a subsequent `start_i` restarts cleanly at the new `head_addr_i`.

Source files
------------

// File: rtl/ndma_desc_fetch.sv
// ndma_desc_fetch
// ---------------
// Descriptor-chain front end for the nDMA engine. Walks a linked list of
// 4-word descriptors {src, dst, len, next} over a dedicated OBI read
// manager. Each legal descriptor is programmed into the nDMA config port
// (src, dst, len, then a start write). The block then waits for the core's
// completion interrupt before following the next pointer.
//
// Ports
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   start_i, head_addr_i   : start a chain walk at head_addr_i (IDLE only)
//   abort_i                : stop the walk at the next safe point
//   busy_o                 : high whenever not IDLE
//   chain_done_o, err_o    : single-cycle completion / illegal-length pulses
//   desc_cnt_o             : descriptors completed since the last start
//   desc_mgr_*             : OBI read manager for descriptor fetches
//   cfg_*                  : config write port into the nDMA core
//   tx_done_irq_i          : transfer-complete indication from the core
//
// All outputs come straight from flops; next values are computed from the
// next state so that requests appear in the first cycle of FETCH/CFG.

module ndma_desc_fetch #(
  parameter int unsigned MaxTxSize = 256,
  parameter logic [31:0] CfgBase   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] head_addr_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        chain_done_o,
  output logic        err_o,
  output logic [15:0] desc_cnt_o,
  output logic        desc_mgr_req_o,
  output logic [31:0] desc_mgr_addr_o,
  output logic        desc_mgr_we_o,
  output logic [3:0]  desc_mgr_be_o,
  output logic [31:0] desc_mgr_wdata_o,
  input  logic        desc_mgr_gnt_i,
  input  logic        desc_mgr_rvalid_i,
  input  logic [31:0] desc_mgr_rdata_i,
  output logic        cfg_req_o,
  output logic        cfg_we_o,
  input  logic        cfg_gnt_i,
  output logic [31:0] cfg_addr_o,
  output logic [31:0] cfg_wdata_o,
  input  logic        cfg_rvalid_i,
  input  logic        tx_done_irq_i
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FWAIT,
    CHECK,
    CFG,
    CWAIT,
    XFER
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [1:0]  widx_q, widx_d;
  logic [1:0]  cidx_q, cidx_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;
  logic [31:0] next_q, next_d;
  logic        abort_q, abort_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        dreq_q, dreq_d;
  logic [31:0] daddr_q, daddr_d;
  logic        creq_q, creq_d;
  logic [31:0] caddr_q, caddr_d;
  logic [31:0] cwdata_q, cwdata_d;

  logic        abort_seen;
  logic        len_bad;

  // Constant ties on the read manager and config port.
  assign desc_mgr_we_o    = 1'b0;
  assign desc_mgr_be_o    = 4'hF;
  assign desc_mgr_wdata_o = 32'h0;
  assign cfg_we_o         = 1'b1;

  assign busy_o          = busy_q;
  assign chain_done_o    = done_q;
  assign err_o           = err_q;
  assign desc_cnt_o      = cnt_q;
  assign desc_mgr_req_o  = dreq_q;
  assign desc_mgr_addr_o = daddr_q;
  assign cfg_req_o       = creq_q;
  assign cfg_addr_o      = caddr_q;
  assign cfg_wdata_o     = cwdata_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    widx_d  = widx_q;
    cidx_d  = cidx_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    next_d  = next_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // A pending abort includes one arriving this very cycle so that an
    // abort in XFER takes effect on the next edge.
    abort_seen = abort_q | abort_i;
    len_bad    = (len_q == 32'd0) || (len_q > MaxTxSize);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          ptr_d   = head_addr_i & ~32'h3;
          widx_d  = 2'd0;
          cnt_d   = 16'd0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (desc_mgr_gnt_i) state_d = FWAIT;
      end
      FWAIT: begin
        if (desc_mgr_rvalid_i) begin
          case (widx_q)
            2'd0:    src_d  = desc_mgr_rdata_i;
            2'd1:    dst_d  = desc_mgr_rdata_i;
            2'd2:    len_d  = desc_mgr_rdata_i;
            default: next_d = desc_mgr_rdata_i;
          endcase
          if (widx_q == 2'd3) begin
            state_d = CHECK;
          end else begin
            widx_d  = widx_q + 2'd1;
            state_d = abort_seen ? IDLE : FETCH;
          end
        end
      end
      CHECK: begin
        // An illegal length wins over a pending abort so the error is seen.
        if (len_bad) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cidx_d  = 2'd0;
          state_d = abort_seen ? IDLE : CFG;
        end
      end
      CFG: begin
        if (cfg_gnt_i) state_d = CWAIT;
      end
      CWAIT: begin
        if (cfg_rvalid_i) begin
          if (cidx_q == 2'd3) begin
            state_d = XFER;
          end else begin
            cidx_d  = cidx_q + 2'd1;
            state_d = abort_seen ? IDLE : CFG;
          end
        end
      end
      XFER: begin
        // The running transfer is left alone on abort; a completion that
        // lands in the same cycle is still counted.
        if (tx_done_irq_i) cnt_d = cnt_q + 16'd1;
        if (abort_seen) begin
          state_d = IDLE;
        end else if (tx_done_irq_i) begin
          if (next_q == 32'd0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ptr_d   = next_q & ~32'h3;
            widx_d  = 2'd0;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort is only remembered while busy and is forgotten on entering IDLE,
    // which also drops an abort that coincides with start.
    if (state_d == IDLE || state_q == IDLE) begin
      abort_d = 1'b0;
    end else begin
      abort_d = abort_seen;
    end

    busy_d   = (state_d != IDLE);
    dreq_d   = (state_d == FETCH);
    daddr_d  = dreq_d ? (ptr_d + {28'd0, widx_d, 2'b00}) : 32'h0;
    creq_d   = (state_d == CFG);
    caddr_d  = creq_d ? (CfgBase + {28'd0, cidx_d, 2'b00}) : 32'h0;
    cwdata_d = 32'h0;
    if (creq_d) begin
      case (cidx_d)
        2'd0:    cwdata_d = src_d;
        2'd1:    cwdata_d = dst_d;
        2'd2:    cwdata_d = len_d;
        default: cwdata_d = 32'h1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= 32'h0;
      widx_q   <= 2'd0;
      cidx_q   <= 2'd0;
      src_q    <= 32'h0;
      dst_q    <= 32'h0;
      len_q    <= 32'h0;
      next_q   <= 32'h0;
      abort_q  <= 1'b0;
      cnt_q    <= 16'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dreq_q   <= 1'b0;
      daddr_q  <= 32'h0;
      creq_q   <= 1'b0;
      caddr_q  <= 32'h0;
      cwdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      widx_q   <= widx_d;
      cidx_q   <= cidx_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      next_q   <= next_d;
      abort_q  <= abort_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dreq_q   <= dreq_d;
      daddr_q  <= daddr_d;
      creq_q   <= creq_d;
      caddr_q  <= caddr_d;
      cwdata_q <= cwdata_d;
    end
  end

endmodule
